// File: rtl/ddr4_req_queue_if.sv
// ddr4_req_queue_if: CPU request/response and controller-side signals of the DDR4 request queue
interface ddr4_req_queue_if #(parameter int DEPTH = 8, parameter int AW = 31, parameter int DW = 4);
  localparam int CW = $clog2(DEPTH) + 1;
  logic req_valid;
  logic req_ready;
  logic req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdat;
  logic rsp_valid;
  logic [DW-1:0] rsp_dat;
  logic crd;
  logic cwr;
  logic [AW-1:0] ca;
  logic [DW-1:0] cwdat;
  logic [DW-1:0] crdat;
  logic [3:0] curr_state;
  logic [CW-1:0] q_count;
  logic wd_err;
  modport master(
    output req_valid, req_wr, req_addr, req_wdat, crdat, curr_state,
    input req_ready, rsp_valid, rsp_dat, crd, cwr, ca, cwdat, q_count, wd_err
  );
  modport slave(
    input req_valid, req_wr, req_addr, req_wdat, crdat, curr_state,
    output req_ready, rsp_valid, rsp_dat, crd, cwr, ca, cwdat, q_count, wd_err
  );
endinterface

// File: rtl/ddr4_req_queue.sv
// ddr4_req_queue: in-order request FIFO feeding the DDR4 controller one transaction at a time.
// Optional watchdog enabled by defining DDR4_REQ_WATCHDOG_EN.
module ddr4_req_queue #(
  parameter int DEPTH = 8,
  parameter int AW = 31,
  parameter int DW = 4,
  parameter logic [3:0] ST_IDLE = 4'd5,
  parameter logic [3:0] ST_READ = 4'd6,
  parameter logic [3:0] ST_WRITE = 4'd7
`ifdef DDR4_REQ_WATCHDOG_EN
  , parameter int TIMEOUT = 4096
`endif
) (
  input logic clkin,
  input logic crst,
  ddr4_req_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {EMPTY, PRESENT, ACCEPTED} state_t;
  state_t r_state, w_state_nx;
  logic [AW-1:0] r_mem_addr [DEPTH];
  logic [DW-1:0] r_mem_wdat [DEPTH];
  logic [DEPTH-1:0] r_mem_wr;
  logic [PW-1:0] r_wptr, r_rptr, w_rptr_nx, w_head_ptr;
  logic [PW:0] r_count;
  logic r_wr, r_crd, r_cwr, r_rsp_valid;
  logic [AW-1:0] r_ca;
  logic [DW-1:0] r_cwdat, r_rsp_dat;
  logic w_push, w_pop, w_busy, w_issue, w_bypass, w_head_wr;
  logic [AW-1:0] w_head_addr;
  logic [DW-1:0] w_head_wdat;
  assign bus.req_ready = r_count < (PW+1)'(DEPTH);
  assign w_push = bus.req_valid & bus.req_ready;
  assign w_pop = r_state == ACCEPTED && bus.curr_state == ST_IDLE;
  assign w_busy = bus.curr_state == ST_READ || bus.curr_state == ST_WRITE;
  assign w_rptr_nx = r_rptr + PW'(1);
  // An empty queue presents the incoming request directly; a pop presents the entry behind the head
  assign w_bypass = r_count == '0;
  assign w_head_ptr = r_state == ACCEPTED ? w_rptr_nx : r_rptr;
  assign w_head_wr = w_bypass ? bus.req_wr : r_mem_wr[w_head_ptr];
  assign w_head_addr = w_bypass ? bus.req_addr : r_mem_addr[w_head_ptr];
  assign w_head_wdat = w_bypass ? bus.req_wdat : r_mem_wdat[w_head_ptr];
  assign w_issue = (r_state == EMPTY && (!w_bypass || w_push)) || (w_pop && r_count > (PW+1)'(1));
  always_comb begin
    w_state_nx = r_state;
    if (w_issue) w_state_nx = PRESENT;
    else if (w_pop) w_state_nx = EMPTY;
    else if (r_state == PRESENT && w_busy) w_state_nx = ACCEPTED;
  end
  always_ff @(posedge clkin) begin
    if (crst) r_state <= EMPTY;
    else r_state <= w_state_nx;
  end
  always_ff @(posedge clkin) begin
    if (w_push) begin
      r_mem_addr[r_wptr] <= bus.req_addr;
      r_mem_wdat[r_wptr] <= bus.req_wdat;
      r_mem_wr[r_wptr] <= bus.req_wr;
    end
  end
  always_ff @(posedge clkin) begin
    if (crst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_wr <= 1'b0;
      r_crd <= 1'b0;
      r_cwr <= 1'b0;
      r_ca <= '0;
      r_cwdat <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= w_rptr_nx;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      // Requests drop as soon as the controller starts work so an idle return cannot re-issue them
      r_crd <= w_issue ? ~w_head_wr : r_crd & ~w_busy;
      r_cwr <= w_issue ? w_head_wr : r_cwr & ~w_busy;
      if (w_issue) begin
        r_ca <= w_head_addr;
        r_cwdat <= w_head_wdat;
        r_wr <= w_head_wr;
      end
      r_rsp_valid <= w_pop & ~r_wr;
      if (w_pop & ~r_wr) r_rsp_dat <= bus.crdat;
    end
  end
  assign bus.crd = r_crd;
  assign bus.cwr = r_cwr;
  assign bus.ca = r_ca;
  assign bus.cwdat = r_cwdat;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_dat = r_rsp_dat;
  assign bus.q_count = r_count;
`ifdef DDR4_REQ_WATCHDOG_EN
  logic [15:0] r_wd_cnt;
  logic r_wd_err;
  logic w_wd_run;
  assign w_wd_run = r_state != EMPTY && !w_pop;
  always_ff @(posedge clkin) begin
    if (crst) begin
      r_wd_cnt <= '0;
      r_wd_err <= 1'b0;
    end else begin
      r_wd_cnt <= !w_wd_run ? '0 : r_wd_cnt + {15'd0, r_wd_cnt != 16'hFFFF};
      r_wd_err <= r_wd_err | (w_wd_run && r_wd_cnt == 16'(TIMEOUT - 1));
    end
  end
  assign bus.wd_err = r_wd_err;
`else
  assign bus.wd_err = 1'b0;
`endif
endmodule

// File: doc/ddr4_req_queue.md
Name: ddr4_req_queue

Overview:
- Request buffer that sits directly upstream of the DDR4 controller, on its CPU side.
- Accepts CPU read/write requests through a valid/ready handshake and stores them in an in-order FIFO.
- Presents the head request on the controller's crd/cwr/ca/cwdat inputs and holds it for exactly one controller transaction.
- Pops the head once the controller returns to idle, and returns read data to the CPU. The controller's 4-bit state output is the only completion indication.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, ≥2).
- AW, 31, CPU address width (bg[30:29], ba[28:27], row[26:10], col[9:0]).
- DW, 4, data width.
- ST_IDLE, 5, controller idle state code.
- ST_READ, 6, controller read state code.
- ST_WRITE, 7, controller write state code.
- TIMEOUT, 4096, watchdog limit in cycles (WATCHDOG_EN only).

Ports:
- clkin  in  1  clock; all logic on rising edge.
- crst  in  1  reset, synchronous, active-high.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  queue can accept.
- req_wr  in  1  1=write, 0=read.
- req_addr  in  AW  request address.
- req_wdat  in  DW  write data.
- rsp_valid  out  1  one-cycle pulse, read complete.
- rsp_dat  out  DW  read data, valid with rsp_valid.
- crd  out  1  to controller read request.
- cwr  out  1  to controller write request.
- ca  out  AW  to controller address.
- cwdat  out  DW  to controller write data.
- crdat  in  DW  from controller read data.
- curr_state  in  4  from controller FSM state.
- q_count  out  log2(DEPTH)+1  occupancy.
- wd_err  out  1  sticky watchdog error (0 when WATCHDOG_EN undefined).

Behaviour:
- Reset (crst=1 at an edge):
  - count=0, pointers=0, FSM=EMPTY.
  - crd=0, cwr=0, ca=0, cwdat=0, rsp_valid=0, rsp_dat=0, wd_err=0. req_ready=1 in the first cycle after reset.
  - Reset mid-transaction discards all entries; no rsp is issued.
- Push:
  - Occurs when req_valid & req_ready at the edge.
  - req_ready = (count < DEPTH), combinational from registered count. When full, no push is accepted even if a pop happens in the same cycle.
  - Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
- FSM (registered outputs):
  - EMPTY:
    - crd=cwr=0.
    - If count≠0, or a push occurs this cycle, go to PRESENT next cycle. Entry-to-present latency is 1 cycle after the push edge.
    - On entering PRESENT, load ca and cwdat from the head, and set crd=~wr, cwr=wr.
  - PRESENT:
    - Hold crd/cwr/ca/cwdat stable.
    - When curr_state==ST_READ or ST_WRITE, go to ACCEPTED and drive crd=cwr=0 from the next edge. This prevents a repeat issue when the controller re-enters idle.
    - ca and cwdat remain held.
  - ACCEPTED:
    - Hold ca/cwdat.
    - When curr_state==ST_IDLE: pop the head. If the request was a read, pulse rsp_valid for 1 cycle with rsp_dat=crdat sampled at that edge.
    - Then go to PRESENT if count-1>0, loading the new head in the same edge; otherwise go to EMPTY.
- A curr_state value of ST_IDLE while in PRESENT does not pop: the controller may sit idle during activation/precharge or refresh.
- Any other curr_state values (waiting, init, refresh) cause no transition.
- Strict in-order service. At most one outstanding transaction to the controller.

Optional Feature:
- DDR4_REQ_WATCHDOG_EN defined:
  - A 16-bit counter clears on EMPTY and on every pop, and increments each cycle spent in PRESENT or ACCEPTED.
  - On reaching TIMEOUT, wd_err is set and stays set until crst. Queue operation is otherwise unchanged.
- Undefined: no counter is built; wd_err is tied to 0.

Test Plan:
- Reset then single read at addr 0x0000_0405, curr_state driven 5→6→4…4→5:
  - crd=1 and ca=0x0000_0405 one cycle after push.
  - crd=0 after state 6 is seen.
  - rsp_valid pulses once with rsp_dat=crdat (4'hA) on return to 5.
  - q_count returns to 0.
- Push 8 writes back-to-back with the controller stalled in 4:
  - req_ready=0 after the 8th push; q_count=8.
  - A 9th req_valid is not accepted.
- Full queue with a simultaneous push and pop: the push is refused and q_count becomes 7. Then push+pop at q_count=3 leaves q_count=3, and data order is preserved across pointer wrap.
- PRESENT with curr_state held at 5 for 20 cycles (row miss, controller idle) → no pop, crd stays 1 throughout; pop occurs only after a 6 then 5 sequence.
- crst asserted while in ACCEPTED with 3 entries → next cycle q_count=0, crd=cwr=0, and no rsp_valid.
- With DDR4_REQ_WATCHDOG_EN and TIMEOUT=16, hold curr_state=4 after issue → wd_err=1 after 16 cycles and stays 1 until crst.
